// File: rtl/fc_xcvr_pkg.sv
`default_nettype none
// ============================================================================
// Package : fc_xcvr_pkg
// Brief   : Shared constants, aligner state type and helpers for the FC
//           transceiver model (idle ordered set, K28.5 codes, comma patterns).
// Rev     : 1.0 - initial release
// ============================================================================
package fc_xcvr_pkg;

    localparam logic [9:0] K28_5_RDN = 10'b0011111010;
    localparam logic [9:0] K28_5_RDP = 10'b1100000101;

    localparam logic [6:0] COMMA_POS = 7'b0011111;
    localparam logic [6:0] COMMA_NEG = 7'b1100000;

    // Idle ordered set: K28.5, D21.4, D21.5, D21.5
    localparam logic [7:0] IDLE_BYTE_0 = 8'hBC;
    localparam logic [7:0] IDLE_BYTE_1 = 8'h95;
    localparam logic [7:0] IDLE_BYTE_2 = 8'hB5;
    localparam logic [7:0] IDLE_BYTE_3 = 8'hB5;

    localparam int LOSS_SYMBOLS = 4;

    typedef enum logic [1:0] {
        UNSYNCED = 2'd0,
        COUNTING = 2'd1,
        SYNCED   = 2'd2
    } align_state_t;

    function automatic logic [7:0] idle_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return IDLE_BYTE_0;
            2'd1:    return IDLE_BYTE_1;
            2'd2:    return IDLE_BYTE_2;
            default: return IDLE_BYTE_3;
        endcase
    endfunction

    function automatic logic is_comma(input logic [9:0] win);
        return (win[9:3] == COMMA_POS) || (win[9:3] == COMMA_NEG);
    endfunction

    function automatic logic sym_valid(input logic [9:0] sym);
        int ones;
        ones = $countones(sym);
        return (ones >= 4) && (ones <= 6);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fc_xcvr_if.sv
`default_nettype none
// ============================================================================
// Interface : fc_xcvr_if
// Brief     : Serial lines and status outputs of the FC transceiver.
// Rev       : 1.0 - initial release
// ============================================================================
interface fc_xcvr_if;
    logic       rx_serial_data;
    logic       tx_serial_data;
    logic       pll_locked;
    logic       tx_ready;
    logic       rx_ready;
    logic       rx_syncstatus;
    logic [9:0] rx_symbol;

    modport master (
        input  rx_serial_data,
        output tx_serial_data,
        output pll_locked,
        output tx_ready,
        output rx_ready,
        output rx_syncstatus,
        output rx_symbol
    );

    modport slave (
        output rx_serial_data,
        input  tx_serial_data,
        input  pll_locked,
        input  tx_ready,
        input  rx_ready,
        input  rx_syncstatus,
        input  rx_symbol
    );
endinterface
`default_nettype wire

// File: rtl/enc_8b10b.sv
`default_nettype none
// ============================================================================
// Module : enc_8b10b
// Brief  : Combinational 8b/10b encoder (5b/6b + 3b/4b, D.x.A7 alternate),
//          symbol bit 9 = 'a', bit 0 = 'j'.
// Rev    : 1.0 - initial release
// ============================================================================
module enc_8b10b (
    input  wire logic [7:0] i_data,
    input  wire logic       i_k,
    input  wire logic       i_rd,
    output logic      [9:0] o_sym,
    output logic            o_rd
);
    logic [4:0] w_x;
    logic [2:0] w_y;
    logic [5:0] w_c6;
    logic [3:0] w_c4;
    logic       w_unbal6;
    logic       w_flip6;
    logic       w_rd6;
    logic       w_alt7;
    logic       w_rd_dep4;
    logic       w_unbal4;
    logic [5:0] w_sym6;
    logic [3:0] w_sym4;

    assign w_x = i_data[4:0];
    assign w_y = i_data[7:5];

    // 6b codes as sent at RD-; unbalanced ones (and D.7) are inverted at RD+
    always_comb begin
        w_c6 = 6'b000000;
        case (w_x)
            5'd0:  w_c6 = 6'b100111;  5'd1:  w_c6 = 6'b011101;
            5'd2:  w_c6 = 6'b101101;  5'd3:  w_c6 = 6'b110001;
            5'd4:  w_c6 = 6'b110101;  5'd5:  w_c6 = 6'b101001;
            5'd6:  w_c6 = 6'b011001;  5'd7:  w_c6 = 6'b111000;
            5'd8:  w_c6 = 6'b111001;  5'd9:  w_c6 = 6'b100101;
            5'd10: w_c6 = 6'b010101;  5'd11: w_c6 = 6'b110100;
            5'd12: w_c6 = 6'b001101;  5'd13: w_c6 = 6'b101100;
            5'd14: w_c6 = 6'b011100;  5'd15: w_c6 = 6'b010111;
            5'd16: w_c6 = 6'b011011;  5'd17: w_c6 = 6'b100011;
            5'd18: w_c6 = 6'b010011;  5'd19: w_c6 = 6'b110010;
            5'd20: w_c6 = 6'b001011;  5'd21: w_c6 = 6'b101010;
            5'd22: w_c6 = 6'b011010;  5'd23: w_c6 = 6'b111010;
            5'd24: w_c6 = 6'b110011;  5'd25: w_c6 = 6'b100110;
            5'd26: w_c6 = 6'b010110;  5'd27: w_c6 = 6'b110110;
            5'd28: w_c6 = 6'b001110;  5'd29: w_c6 = 6'b101110;
            5'd30: w_c6 = 6'b011110;  default: w_c6 = 6'b101011;
        endcase
        if (i_k && (w_x == 5'd28)) begin
            w_c6 = 6'b001111;
        end
    end

    assign w_unbal6 = ($countones(w_c6) != 3);
    assign w_flip6  = w_unbal6 || (w_x == 5'd7);
    assign w_rd6    = i_rd ^ w_unbal6;
    assign w_sym6   = (i_rd && w_flip6) ? ~w_c6 : w_c6;

    // Alternate x.7 avoids a run of five equal bits across the 6b/4b seam
    assign w_alt7 = i_k ||
                    (!w_rd6 && ((w_x == 5'd17) || (w_x == 5'd18) || (w_x == 5'd20))) ||
                    ( w_rd6 && ((w_x == 5'd11) || (w_x == 5'd13) || (w_x == 5'd14)));

    always_comb begin
        w_c4 = 4'b0000;
        case (w_y)
            3'd0:    w_c4 = 4'b1011;
            3'd1:    w_c4 = 4'b1001;
            3'd2:    w_c4 = 4'b0101;
            3'd3:    w_c4 = 4'b1100;
            3'd4:    w_c4 = 4'b1101;
            3'd5:    w_c4 = 4'b1010;
            3'd6:    w_c4 = 4'b0110;
            default: w_c4 = w_alt7 ? 4'b0111 : 4'b1110;
        endcase
    end

    assign w_rd_dep4 = (w_y == 3'd0) || (w_y == 3'd3) || (w_y == 3'd4) || (w_y == 3'd7);
    assign w_unbal4  = (w_y == 3'd0) || (w_y == 3'd4) || (w_y == 3'd7);

    // Balanced K.x.y codes are inverted when the 6b part left RD negative
    assign w_sym4 = w_rd_dep4 ? (w_rd6 ? ~w_c4 : w_c4)
                              : ((i_k && !w_rd6) ? ~w_c4 : w_c4);

    assign o_sym = {w_sym6, w_sym4};
    assign o_rd  = w_rd6 ^ w_unbal4;

endmodule
`default_nettype wire

// File: rtl/tb_tb.sv
`default_nettype none
// ============================================================================
// Module : tb_tb
// Brief  : FC transceiver model: reset sequencer, 8b/10b idle TX serializer,
//          RX comma aligner with loss-of-sync detection.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_tb
    import fc_xcvr_pkg::*;
#(
    parameter int PLL_LOCK_CYCLES = 64,
    parameter int TX_READY_CYCLES = 32,
    parameter int RX_READY_CYCLES = 48,
    parameter int SYNC_COMMAS     = 3,
    parameter int LOOPBACK        = 1
) (
    input  wire logic  clk_clk,
    input  wire logic  reset_reset_n,
    fc_xcvr_if.master  xcvr
);
    localparam int c_tx_at    = PLL_LOCK_CYCLES + TX_READY_CYCLES;
    localparam int c_rx_at    = PLL_LOCK_CYCLES + RX_READY_CYCLES;
    localparam int c_done_at  = (c_tx_at > c_rx_at) ? c_tx_at : c_rx_at;
    localparam int c_cnt_w    = $clog2(c_done_at + 1);
    localparam int c_sc_w     = $clog2(SYNC_COMMAS + 1);

    logic [c_cnt_w-1:0] r_cycle;
    logic               r_pll_locked;
    logic               r_tx_ready;
    logic               r_rx_ready;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_cycle      <= '0;
            r_pll_locked <= 1'b0;
            r_tx_ready   <= 1'b0;
            r_rx_ready   <= 1'b0;
        end else begin
            if (r_cycle != c_cnt_w'(c_done_at)) begin
                r_cycle <= r_cycle + 1'b1;
            end
            if (r_cycle == c_cnt_w'(PLL_LOCK_CYCLES - 1)) r_pll_locked <= 1'b1;
            if (r_cycle == c_cnt_w'(c_tx_at - 1))         r_tx_ready   <= 1'b1;
            if (r_cycle == c_cnt_w'(c_rx_at - 1))         r_rx_ready   <= 1'b1;
        end
    end

    logic [3:0] r_bit_idx;
    logic [1:0] r_os_idx;
    logic       r_rd;
    logic       r_tx_bit;
    logic [9:0] w_tx_sym;
    logic       w_tx_rd_next;

    enc_8b10b u_enc (
        .i_data (idle_byte(r_os_idx)),
        .i_k    (r_os_idx == 2'd0),
        .i_rd   (r_rd),
        .o_sym  (w_tx_sym),
        .o_rd   (w_tx_rd_next)
    );

    // Disparity only advances at symbol boundaries, after bit 'j' is sent
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_bit_idx <= 4'd0;
            r_os_idx  <= 2'd0;
            r_rd      <= 1'b0;
            r_tx_bit  <= 1'b0;
        end else if (r_tx_ready) begin
            r_tx_bit <= w_tx_sym[4'd9 - r_bit_idx];
            if (r_bit_idx == 4'd9) begin
                r_bit_idx <= 4'd0;
                r_os_idx  <= r_os_idx + 2'd1;
                r_rd      <= w_tx_rd_next;
            end else begin
                r_bit_idx <= r_bit_idx + 4'd1;
            end
        end
    end

    logic              w_rx_bit;
    logic [9:0]        r_shift;
    align_state_t      r_state;
    logic [3:0]        r_slot;
    logic [c_sc_w-1:0] r_comma_cnt;
    logic [2:0]        r_bad_cnt;
    logic              r_sync;
    logic [9:0]        r_symbol;
    logic              w_comma;
    logic              w_aligned;
    logic              w_valid;

    assign w_rx_bit  = (LOOPBACK != 0) ? r_tx_bit : xcvr.rx_serial_data;
    assign w_comma   = is_comma(r_shift);
    assign w_aligned = (r_slot == 4'd0);
    assign w_valid   = sym_valid(r_shift);

    // r_slot == 0 marks the cycle in which r_shift holds a whole aligned symbol
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_shift     <= 10'h000;
            r_state     <= UNSYNCED;
            r_slot      <= 4'd0;
            r_comma_cnt <= '0;
            r_bad_cnt   <= 3'd0;
            r_sync      <= 1'b0;
            r_symbol    <= 10'h000;
        end else if (r_rx_ready) begin
            r_shift <= {r_shift[8:0], w_rx_bit};
            r_slot  <= (r_slot == 4'd9) ? 4'd0 : r_slot + 4'd1;
            case (r_state)
                UNSYNCED: begin
                    if (w_comma) begin
                        r_slot      <= 4'd1;
                        r_comma_cnt <= c_sc_w'(1);
                        if (SYNC_COMMAS <= 1) begin
                            r_state  <= SYNCED;
                            r_sync   <= 1'b1;
                            r_symbol <= r_shift;
                        end else begin
                            r_state <= COUNTING;
                        end
                    end
                end
                COUNTING: begin
                    if (w_comma && w_aligned) begin
                        if (r_comma_cnt >= c_sc_w'(SYNC_COMMAS - 1)) begin
                            r_state   <= SYNCED;
                            r_sync    <= 1'b1;
                            r_symbol  <= r_shift;
                            r_bad_cnt <= 3'd0;
                        end else begin
                            r_comma_cnt <= r_comma_cnt + 1'b1;
                        end
                    end else if (w_comma) begin
                        r_slot      <= 4'd1;
                        r_comma_cnt <= c_sc_w'(1);
                    end
                end
                SYNCED: begin
                    // Off-phase commas are ignored here; only bad symbols drop lock
                    if (w_aligned) begin
                        r_symbol <= r_shift;
                        if (w_valid) begin
                            r_bad_cnt <= 3'd0;
                        end else if (r_bad_cnt == 3'(LOSS_SYMBOLS - 1)) begin
                            r_bad_cnt <= 3'd0;
                            r_state   <= UNSYNCED;
                            r_sync    <= 1'b0;
                        end else begin
                            r_bad_cnt <= r_bad_cnt + 3'd1;
                        end
                    end
                end
                default: begin
                    r_state <= UNSYNCED;
                    r_sync  <= 1'b0;
                end
            endcase
        end
    end

    assign xcvr.tx_serial_data = r_tx_bit;
    assign xcvr.pll_locked     = r_pll_locked;
    assign xcvr.tx_ready       = r_tx_ready;
    assign xcvr.rx_ready       = r_rx_ready;
    assign xcvr.rx_syncstatus  = r_sync;
    assign xcvr.rx_symbol      = r_symbol;

endmodule
`default_nettype wire

// File: tb/tb_tb_tb.sv
`default_nettype none
// ============================================================================
// Module : tb_tb_tb
// Brief  : Self-checking bench for tb_tb: bring-up timing, TX idle stream,
//          loopback sync, external slip / stuck line, mid-stream reset.
// Rev    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_tb_tb;
    localparam logic [9:0]  SYM_K285N = 10'b0011111010;
    localparam logic [9:0]  SYM_K285P = 10'b1100000101;
    localparam logic [9:0]  SYM_D214P = 10'b1010100010;
    localparam logic [9:0]  SYM_D215  = 10'b1010101010;
    localparam logic [19:0] EXT_PAT   = {10'b0011111010, 10'b1100000101};

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fc_xcvr_if lb_if ();
    fc_xcvr_if ext_if ();

    tb_tb #(.LOOPBACK(1)) u_dut_lb (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .xcvr          (lb_if)
    );

    tb_tb #(.LOOPBACK(0)) u_dut_ext (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .xcvr          (ext_if)
    );

    int         n_vectors     = 0;
    int         n_miscompares = 0;
    logic [9:0] exp_q[$];
    logic       ext_stuck     = 1'b0;
    int         ext_skip_req  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // External RX source: alternating-disparity K28.5 stream, with bit slip / stuck-at-0
    initial begin : ext_gen
        int idx;
        int skips_done;
        idx = 0;
        skips_done = 0;
        ext_if.rx_serial_data = 1'b0;
        forever begin
            @(negedge clk);
            if (ext_skip_req != skips_done) begin
                skips_done = ext_skip_req;
                idx = (idx + 1) % 20;
            end
            ext_if.rx_serial_data = ext_stuck ? 1'b0 : EXT_PAT[19 - idx];
            idx = (idx + 1) % 20;
        end
    end

    function automatic logic [14:0] lb_outs();
        return {lb_if.tx_serial_data, lb_if.pll_locked, lb_if.tx_ready,
                lb_if.rx_ready, lb_if.rx_syncstatus, lb_if.rx_symbol};
    endfunction

    // Counts posedges from reset release; checks ready timing and first 40 TX bits
    task automatic run_bringup();
        logic [9:0] acc;
        int         nb;
        acc = '0;
        nb  = 0;
        for (int k = 1; k <= 136; k++) begin
            @(posedge clk);
            #1;
            case (k)
                63:  check_val("pll_locked@63",  lb_if.pll_locked, 1'b0);
                64:  check_val("pll_locked@64",  lb_if.pll_locked, 1'b1);
                95:  check_val("tx_ready@95",    {lb_if.tx_ready, lb_if.tx_serial_data}, 2'b00);
                96:  check_val("tx_ready@96",    lb_if.tx_ready, 1'b1);
                111: check_val("rx_ready@111",   lb_if.rx_ready, 1'b0);
                112: check_val("rx_ready@112",   lb_if.rx_ready, 1'b1);
                default: ;
            endcase
            if (k == 96) begin
                exp_q.push_back(SYM_K285N);
                exp_q.push_back(SYM_D214P);
                exp_q.push_back(SYM_D215);
                exp_q.push_back(SYM_D215);
            end
            if (k >= 97) begin
                acc = {acc[8:0], lb_if.tx_serial_data};
                nb++;
                if (nb == 10) begin
                    nb = 0;
                    if (exp_q.size() > 0) check_val("tx_symbol", acc, exp_q.pop_front());
                end
            end
        end
        check_val("tx_queue_drained", exp_q.size(), 0);
        check_val("lb_sync_early", lb_if.rx_syncstatus, 1'b0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin : main
        logic found;
        rst_n = 1'b0;
        lb_if.rx_serial_data = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_val("reset_outputs", lb_outs(), 15'h0);

        @(negedge clk);
        rst_n = 1'b1;
        run_bringup();

        // Loopback: sync within 130 cycles of rx_ready (24 already elapsed)
        found = 1'b0;
        for (int i = 0; i < 106 && !found; i++) begin
            @(posedge clk);
            #1;
            if (lb_if.rx_syncstatus) found = 1'b1;
        end
        check_val("lb_sync_acquire", found, 1'b1);

        for (int r = 0; r < 2; r++) begin
            exp_q.push_back(SYM_K285N);
            exp_q.push_back(SYM_D214P);
            exp_q.push_back(SYM_D215);
            exp_q.push_back(SYM_D215);
        end
        while (exp_q.size() > 0) begin
            check_val("lb_rx_symbol", lb_if.rx_symbol, exp_q.pop_front());
            check_val("lb_sync_hold", lb_if.rx_syncstatus, 1'b1);
            repeat (10) @(posedge clk);
            #1;
        end

        // External: bit slip drops sync after 4 bad symbols, then re-locks
        check_val("ext_sync_before_slip", ext_if.rx_syncstatus, 1'b1);
        check_val("ext_symbol_k285",
                  (ext_if.rx_symbol == SYM_K285N) || (ext_if.rx_symbol == SYM_K285P), 1'b1);
        ext_skip_req++;
        repeat (20) @(posedge clk);
        #1;
        check_val("ext_sync_hold_after_slip", ext_if.rx_syncstatus, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            @(posedge clk);
            #1;
            if (!ext_if.rx_syncstatus) found = 1'b1;
        end
        check_val("ext_sync_drop", found, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(posedge clk);
            #1;
            if (ext_if.rx_syncstatus) found = 1'b1;
        end
        check_val("ext_sync_reacquire", found, 1'b1);
        check_val("ext_relock_symbol",
                  (ext_if.rx_symbol == SYM_K285N) || (ext_if.rx_symbol == SYM_K285P), 1'b1);
        repeat (10) @(posedge clk);
        #1;
        check_val("ext_relock_next_symbol",
                  (ext_if.rx_symbol == SYM_K285N) || (ext_if.rx_symbol == SYM_K285P), 1'b1);

        // External line stuck at 0
        ext_stuck = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check_val("ext_stuck_hold", ext_if.rx_syncstatus, 1'b1);
        repeat (35) @(posedge clk);
        #1;
        check_val("ext_stuck_drop", ext_if.rx_syncstatus, 1'b0);

        // Mid-stream asynchronous reset
        check_val("lb_sync_before_reset", lb_if.rx_syncstatus, 1'b1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_val("reset_async_lb", lb_outs(), 15'h0);
        check_val("reset_async_ext",
                  {ext_if.rx_ready, ext_if.rx_syncstatus, ext_if.rx_symbol}, 12'h0);
        repeat (2) @(negedge clk);
        check_val("reset_held_lb", lb_outs(), 15'h0);
        ext_stuck = 1'b0;
        rst_n = 1'b1;
        run_bringup();

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
`default_nettype wire
